// File: rtl/simple_fixed2_pipe.sv
// -----------------------------------------------------------------------------
// simple_fixed2_pipe
//
// SPU "simple fixed 2" execution pipe: halfword/word shift-left and
// rotate-left, in register (RR) and 7-bit immediate (RI7) forms. The result
// is computed at issue and then carried through LATENCY stage registers to
// the write-back outputs. The pipe supports a flush and keeps a count of
// live ops.
//
// Vectors are big-endian in the architecture (bit 0 is the MSB). Here they
// are declared descending, so architectural bit i is physical bit
// DATA_W-1-i. Halfword lane 0 is therefore the most significant 16 bits.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   asynchronous reset, active low
//   flush         in   kills every in-flight op and the op issuing this cycle
//   op            in   11-bit decoded opcode
//   format        in   0 = RR, 1 = RI7, anything else = nop
//   rt_addr       in   destination register address
//   ra, rb        in   source operands
//   imm           in   18-bit immediate; RI7 count is the low 7 bits
//   reg_write     in   issuing op writes the register file
//   rt_wb         out  result at write-back
//   rt_addr_wb    out  destination for rt_wb
//   reg_write_wb  out  rt_wb is valid and must be written
//   inflight      out  number of live ops in the pipe (0..LATENCY)
// -----------------------------------------------------------------------------
module simple_fixed2_pipe #(
    parameter int DATA_W  = 128,
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [10:0]       op,
    input  logic [2:0]        format,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [DATA_W-1:0] ra,
    input  logic [DATA_W-1:0] rb,
    input  logic [17:0]       imm,
    input  logic              reg_write,
    output logic [DATA_W-1:0] rt_wb,
    output logic [ADDR_W-1:0] rt_addr_wb,
    output logic              reg_write_wb,
    output logic [3:0]        inflight
);

    localparam int NUM_H = DATA_W / 16;
    localparam int NUM_W = DATA_W / 32;

    localparam logic [10:0] OP_SHLH  = 11'b00001011111;
    localparam logic [10:0] OP_SHL   = 11'b00001011011;
    localparam logic [10:0] OP_ROTH  = 11'b00001011100;
    localparam logic [10:0] OP_ROT   = 11'b00001011000;
    localparam logic [10:0] OP_SHLHI = 11'b00001111111;
    localparam logic [10:0] OP_SHLI  = 11'b00001111011;
    localparam logic [10:0] OP_ROTHI = 11'b00001111100;
    localparam logic [10:0] OP_ROTI  = 11'b00001111000;

    typedef enum logic [2:0] {
        K_NONE,
        K_SHLH,
        K_SHL,
        K_ROTH,
        K_ROT
    } kind_e;

    kind_e kind;
    logic  use_i7;

    // -------------------------------------------------------------------------
    // Decode
    // -------------------------------------------------------------------------
    always_comb begin
        kind   = K_NONE;
        use_i7 = 1'b0;
        case (format)
            3'd0: begin
                case (op)
                    OP_SHLH: kind = K_SHLH;
                    OP_SHL:  kind = K_SHL;
                    OP_ROTH: kind = K_ROTH;
                    OP_ROT:  kind = K_ROT;
                    default: kind = K_NONE;
                endcase
            end
            3'd1: begin
                use_i7 = 1'b1;
                case (op)
                    OP_SHLHI: kind = K_SHLH;
                    OP_SHLI:  kind = K_SHL;
                    OP_ROTHI: kind = K_ROTH;
                    OP_ROTI:  kind = K_ROT;
                    default:  kind = K_NONE;
                endcase
            end
            default: begin
                kind   = K_NONE;
                use_i7 = 1'b0;
            end
        endcase
    end

    // Sign-extending I7 never changes its low 6 bits, and no count rule looks
    // above bit 5, so the immediate count is used directly from imm[5:0].
    logic unused_imm;
    assign unused_imm = ^imm[17:6];

    // -------------------------------------------------------------------------
    // Lane datapath
    // -------------------------------------------------------------------------
    logic [DATA_W-1:0] res_h;
    logic [DATA_W-1:0] res_w;
    logic [15:0]       lane_h;
    logic [4:0]        cnt_h;
    logic [31:0]       lane_w;
    logic [5:0]        cnt_w;

    always_comb begin
        res_h  = '0;
        res_w  = '0;
        lane_h = '0;
        cnt_h  = '0;
        lane_w = '0;
        cnt_w  = '0;

        for (int h = 0; h < NUM_H; h++) begin
            lane_h = ra[DATA_W-16-16*h +: 16];
            cnt_h  = use_i7 ? imm[4:0] : rb[DATA_W-16-16*h +: 5];
            if (kind == K_SHLH) begin
                // count 16..31 shifts everything out
                res_h[DATA_W-16-16*h +: 16] = cnt_h[4] ? 16'h0000 : (lane_h << cnt_h[3:0]);
            end else begin
                res_h[DATA_W-16-16*h +: 16] = (lane_h << cnt_h[3:0])
                                            | (lane_h >> (5'd16 - {1'b0, cnt_h[3:0]}));
            end
        end

        for (int w = 0; w < NUM_W; w++) begin
            lane_w = ra[DATA_W-32-32*w +: 32];
            cnt_w  = use_i7 ? imm[5:0] : rb[DATA_W-32-32*w +: 6];
            if (kind == K_SHL) begin
                res_w[DATA_W-32-32*w +: 32] = cnt_w[5] ? 32'h0000_0000 : (lane_w << cnt_w[4:0]);
            end else begin
                res_w[DATA_W-32-32*w +: 32] = (lane_w << cnt_w[4:0])
                                            | (lane_w >> (6'd32 - {1'b0, cnt_w[4:0]}));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Issue
    // -------------------------------------------------------------------------
    logic              valid_d;
    logic [DATA_W-1:0] data_d;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        valid_d = reg_write & (kind != K_NONE) & ~flush;
        data_d  = '0;
        addr_d  = '0;
        if (valid_d) begin
            addr_d = rt_addr;
            if (kind == K_SHLH || kind == K_ROTH) begin
                data_d = res_h;
            end else begin
                data_d = res_w;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage registers; index LATENCY-1 is the write-back stage
    // -------------------------------------------------------------------------
    logic              valid_q [LATENCY];
    logic [DATA_W-1:0] data_q  [LATENCY];
    logic [ADDR_W-1:0] addr_q  [LATENCY];
    logic [3:0]        inflight_q;
    logic [3:0]        inflight_d;

    always_comb begin
        if (flush) begin
            inflight_d = 4'd0;
        end else begin
            inflight_d = inflight_q + {3'd0, valid_d} - {3'd0, valid_q[LATENCY-1]};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                valid_q[k] <= 1'b0;
                data_q[k]  <= '0;
                addr_q[k]  <= '0;
            end
            inflight_q <= 4'd0;
        end else begin
            valid_q[0] <= valid_d;
            data_q[0]  <= data_d;
            addr_q[0]  <= addr_d;
            for (int k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1] & ~flush;
                data_q[k]  <= data_q[k-1];
                addr_q[k]  <= addr_q[k-1];
            end
            inflight_q <= inflight_d;
        end
    end

    assign rt_wb        = data_q[LATENCY-1];
    assign rt_addr_wb   = addr_q[LATENCY-1];
    assign reg_write_wb = valid_q[LATENCY-1];
    assign inflight     = inflight_q;

endmodule

// File: tb/tb_simple_fixed2_pipe.sv
module tb_simple_fixed2_pipe;

    localparam int DW  = 128;
    localparam int LAT = 4;
    localparam int AW  = 7;

    localparam logic [10:0] SHLH  = 11'b00001011111;
    localparam logic [10:0] SHL   = 11'b00001011011;
    localparam logic [10:0] ROTH  = 11'b00001011100;
    localparam logic [10:0] ROT   = 11'b00001011000;
    localparam logic [10:0] SHLHI = 11'b00001111111;
    localparam logic [10:0] SHLI  = 11'b00001111011;
    localparam logic [10:0] ROTHI = 11'b00001111100;
    localparam logic [10:0] ROTI  = 11'b00001111000;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [10:0]   op;
    logic [2:0]    format;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] ra;
    logic [DW-1:0] rb;
    logic [17:0]   imm;
    logic          reg_write;
    logic [DW-1:0] rt_wb;
    logic [AW-1:0] rt_addr_wb;
    logic          reg_write_wb;
    logic [3:0]    inflight;

    simple_fixed2_pipe #(.DATA_W(DW), .LATENCY(LAT), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .op           (op),
        .format       (format),
        .rt_addr      (rt_addr),
        .ra           (ra),
        .rb           (rb),
        .imm          (imm),
        .reg_write    (reg_write),
        .rt_wb        (rt_wb),
        .rt_addr_wb   (rt_addr_wb),
        .reg_write_wb (reg_write_wb),
        .inflight     (inflight)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [10:0]   op;
        logic [2:0]    fmt;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic [17:0]   imm;
        logic          rw;
        logic          exp_v;
        logic [DW-1:0] exp;
    } vec_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
    } sb_t;

    sb_t  sbq[$];
    vec_t vecs[15];
    vec_t idle;
    int   checks = 0;
    int   errors = 0;
    int   peak   = 0;

    function automatic vec_t mk(input logic [10:0] o, input logic [2:0] f,
                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [17:0] i, input logic w,
                                input logic ev, input logic [DW-1:0] e);
        vec_t v;
        v.op = o; v.fmt = f; v.ra = a; v.rb = b; v.imm = i;
        v.rw = w; v.exp_v = ev; v.exp = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, req);
        end
    endtask

    // Compare WB outputs and live count against the scoreboard.
    task automatic monitor();
        int exp_inf;
        exp_inf = sbq.size();
        chk("inflight", DW'(inflight), DW'(exp_inf));
        if (int'(inflight) > peak) peak = int'(inflight);
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            chk("wb_valid", DW'(reg_write_wb), DW'(1));
            chk("wb_data", rt_wb, sbq[0].data);
            chk("wb_addr", DW'(rt_addr_wb), DW'(sbq[0].addr));
            void'(sbq.pop_front());
        end else begin
            chk("wb_idle", DW'(reg_write_wb), DW'(0));
        end
    endtask

    task automatic drive(input vec_t v, input logic fl, input logic [AW-1:0] addr);
        op = v.op; format = v.fmt; ra = v.ra; rb = v.rb; imm = v.imm;
        reg_write = v.rw; rt_addr = addr; flush = fl;
    endtask

    task automatic step(input vec_t v, input logic fl, input logic [AW-1:0] addr);
        @(negedge clk);
        monitor();
        drive(v, fl, addr);
        if (fl) sbq.delete();
        else if (v.exp_v) sbq.push_back('{due: cyc + LAT, data: v.exp, addr: addr});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle = mk(11'd0, 3'd0, '0, '0, 18'd0, 1'b0, 1'b0, '0);

        vecs[0]  = mk(SHLH,  3'd0, {8{16'h0001}}, {8{16'h0004}}, 18'd0, 1'b1, 1'b1, {8{16'h0010}});
        vecs[1]  = mk(SHLH,  3'd0, {8{16'hFFFF}}, {4{16'h0010, 16'h002F}}, 18'd0, 1'b1, 1'b1,
                      {4{16'h0000, 16'h8000}});
        vecs[2]  = mk(ROT,   3'd0, {4{32'h80000001}}, {4{32'd1}}, 18'd0, 1'b1, 1'b1, {4{32'h00000003}});
        vecs[3]  = mk(ROTI,  3'd1, {4{32'h80000001}}, '0, 18'h0007F, 1'b1, 1'b1, {4{32'hC0000000}});
        vecs[4]  = mk(SHL,   3'd0, {4{32'h1}}, {32'd0, 32'd31, 32'd32, 32'h45}, 18'd0, 1'b1, 1'b1,
                      {32'h1, 32'h80000000, 32'h0, 32'h20});
        vecs[5]  = mk(ROTH,  3'd0, {8{16'h8001}},
                      {16'd0, 16'd1, 16'd15, 16'd16, 16'd17, 16'd4, 16'd8, 16'hFFFF}, 18'd0, 1'b1, 1'b1,
                      {16'h8001, 16'h0003, 16'hC000, 16'h8001, 16'h0003, 16'h0018, 16'h0180, 16'hC000});
        vecs[6]  = mk(SHLHI, 3'd1, {8{16'h1234}}, '0, 18'd3, 1'b1, 1'b1, {8{16'h91A0}});
        vecs[7]  = mk(SHLHI, 3'd1, {8{16'h1234}}, '0, 18'h00040, 1'b1, 1'b1, {8{16'h1234}});
        vecs[8]  = mk(SHLHI, 3'd1, {8{16'h1234}}, '0, 18'h00010, 1'b1, 1'b1, {8{16'h0000}});
        vecs[9]  = mk(ROTHI, 3'd1, {8{16'h1234}}, '0, 18'h0007C, 1'b1, 1'b1, {8{16'h4123}});
        vecs[10] = mk(SHLI,  3'd1, {4{32'hDEADBEEF}}, '0, 18'h00020, 1'b1, 1'b1, '0);
        vecs[11] = mk(11'b00001011110, 3'd0, {4{32'h1}}, {4{32'd1}}, 18'd0, 1'b1, 1'b0, '0);
        vecs[12] = mk(SHL,   3'd2, {4{32'h1}}, {4{32'd1}}, 18'd0, 1'b1, 1'b0, '0);
        vecs[13] = mk(SHL,   3'd0, {4{32'h1}}, {4{32'd1}}, 18'd0, 1'b0, 1'b0, '0);
        vecs[14] = mk(SHLH,  3'd1, {8{16'h1}}, '0, 18'd1, 1'b1, 1'b0, '0);

        // reset state
        drive(idle, 1'b0, '0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rt_wb", rt_wb, '0);
        chk("rst_addr", DW'(rt_addr_wb), '0);
        chk("rst_wr", DW'(reg_write_wb), '0);
        chk("rst_inflight", DW'(inflight), '0);
        reset = 1'b1;

        // vector table, issued back to back
        for (int i = 0; i < 15; i++) step(vecs[i], 1'b0, AW'(i + 1));
        repeat (LAT + 2) step(idle, 1'b0, '0);

        // four back-to-back shli with I7 = 1..4
        peak = 0;
        for (int k = 1; k <= 4; k++)
            step(mk(SHLI, 3'd1, {4{32'h1}}, '0, 18'(k), 1'b1, 1'b1, {4{32'(1 << k)}}), 1'b0, AW'(20 + k));
        repeat (LAT + 2) step(idle, 1'b0, '0);
        chk("inflight_peak", DW'(peak), DW'((LAT < 4) ? LAT : 4));

        // flush: op at cycle 0, flush (with a valid op issuing) at cycle 2, new op at cycle 3
        step(mk(SHL, 3'd0, {4{32'h3}}, {4{32'd2}}, 18'd0, 1'b1, 1'b1, {4{32'hC}}), 1'b0, AW'(40));
        step(idle, 1'b0, '0);
        step(mk(ROT, 3'd0, {4{32'h5}}, {4{32'd1}}, 18'd0, 1'b1, 1'b1, {4{32'hA}}), 1'b1, AW'(41));
        @(posedge clk);
        #1;
        chk("inflight_after_flush", DW'(inflight), '0);
        step(mk(SHLH, 3'd0, {8{16'h0101}}, {8{16'd1}}, 18'd0, 1'b1, 1'b1, {8{16'h0202}}), 1'b0, AW'(42));
        repeat (LAT + 2) step(idle, 1'b0, '0);

        // async reset with three ops in flight
        for (int k = 0; k < 3; k++)
            step(mk(ROTI, 3'd1, {4{32'h1}}, '0, 18'(k + 1), 1'b1, 1'b1, {4{32'(2 << k)}}), 1'b0, AW'(50 + k));
        @(posedge clk);
        #1;
        chk("pre_reset_inflight", DW'(inflight), DW'(3));
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_rt_wb", rt_wb, '0);
        chk("midrst_addr", DW'(rt_addr_wb), '0);
        chk("midrst_wr", DW'(reg_write_wb), '0);
        chk("midrst_inflight", DW'(inflight), '0);
        sbq.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(idle, 1'b0, '0);
        repeat (LAT + 2) step(idle, 1'b0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
